// File: rtl/ram_line_fill_responder.sv
// ram_line_fill_responder: memory-side line-fill engine with preloadable internal RAM
module ram_line_fill_responder #(
    parameter int ADDR_W   = 15,
    parameter int DATA_W   = 8,
    parameter int OFFSET_W = 2,
    parameter int LATENCY  = 3
) (
    input  logic                globalclock,
    input  logic                reset_n,
    input  logic                fill_req,
    input  logic [ADDR_W-1:0]   fill_addr,
    output logic                busy,
    output logic                rd_valid,
    output logic [DATA_W-1:0]   rd_data,
    output logic [OFFSET_W-1:0] rd_word_idx,
    output logic                fill_done,
    input  logic                init_we,
    input  logic [ADDR_W-1:0]   init_addr,
    input  logic [DATA_W-1:0]   init_data
);

    localparam int LINE_W = ADDR_W - OFFSET_W;
    localparam logic [OFFSET_W-1:0] LAST = '1;

    typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_t;

    state_t                state;
    logic [3:0]            lat_cnt;
    logic [OFFSET_W-1:0]   word_cnt;
    logic [OFFSET_W-1:0]   next_idx;
    logic [LINE_W-1:0]     line;
    logic [DATA_W-1:0]     mem [0:(1<<ADDR_W)-1];

    assign next_idx = word_cnt + 1'b1;

    // Preload port; writes are only honoured while no fill is in flight
    always_ff @(posedge globalclock)
        if (init_we && state == IDLE) mem[init_addr] <= init_data;

    // Fill sequencer: the index is concatenated below the line, so it can never carry out of the line
    always_ff @(posedge globalclock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            rd_valid    <= 1'b0;
            fill_done   <= 1'b0;
            rd_data     <= '0;
            rd_word_idx <= '0;
            lat_cnt     <= '0;
            word_cnt    <= '0;
            line        <= '0;
        end else begin
            case (state)
                IDLE: if (fill_req) begin
                    state   <= WAIT;
                    busy    <= 1'b1;
                    line    <= fill_addr[ADDR_W-1:OFFSET_W];
                    lat_cnt <= 4'(LATENCY - 1);
                end
                WAIT: if (lat_cnt == '0) begin
                    state       <= BURST;
                    word_cnt    <= '0;
                    rd_valid    <= 1'b1;
                    rd_data     <= mem[{line, {OFFSET_W{1'b0}}}];
                    rd_word_idx <= '0;
                end else begin
                    lat_cnt <= lat_cnt - 1'b1;
                end
                BURST: if (word_cnt == LAST) begin
                    state     <= DONE;
                    rd_valid  <= 1'b0;
                    fill_done <= 1'b1;
                end else begin
                    word_cnt    <= next_idx;
                    rd_data     <= mem[{line, next_idx}];
                    rd_word_idx <= next_idx;
                end
                DONE: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    fill_done <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_line_fill_responder.sv
// tb_ram_line_fill_responder: scoreboard bench for the line-fill responder
module tb_ram_line_fill_responder;

    logic        globalclock = 1'b0;
    logic        reset_n = 1'b0;
    logic        fill_req = 1'b0;
    logic [14:0] fill_addr = '0;
    logic        init_we = 1'b0;
    logic [14:0] init_addr = '0;
    logic [7:0]  init_data = '0;
    logic        busy, rd_valid, fill_done;
    logic [7:0]  rd_data;
    logic [1:0]  rd_word_idx;

    int compared = 0;
    int mismatched = 0;
    int k = 0;
    int valid_seen = 0;
    int done_seen = 0;
    logic [9:0] sb [$];
    logic [7:0] model [0:32767];

    always #5 globalclock = ~globalclock;

    ram_line_fill_responder dut (
        .globalclock(globalclock),
        .reset_n(reset_n),
        .fill_req(fill_req),
        .fill_addr(fill_addr),
        .busy(busy),
        .rd_valid(rd_valid),
        .rd_data(rd_data),
        .rd_word_idx(rd_word_idx),
        .fill_done(fill_done),
        .init_we(init_we),
        .init_addr(init_addr),
        .init_data(init_data)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one cycle, sampling at the falling edge; every valid word is popped from the scoreboard
    task tick();
        logic [9:0] exp;
        @(negedge globalclock);
        k++;
        if (fill_done) done_seen++;
        if (rd_valid) begin
            valid_seen++;
            compared++;
            if (sb.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_word: got idx=%0d data=%h, scoreboard empty", rd_word_idx, rd_data);
            end else begin
                exp = sb.pop_front();
                if ({rd_word_idx, rd_data} !== exp) begin
                    mismatched++;
                    $display("FAIL word: got idx=%0d data=%h, want idx=%0d data=%h",
                             rd_word_idx, rd_data, exp[9:8], exp[7:0]);
                end
            end
        end
    endtask

    task restart();
        k = 0;
        valid_seen = 0;
        done_seen = 0;
    endtask

    task preload(input logic [14:0] a, input logic [7:0] d);
        init_we = 1'b1;
        init_addr = a;
        init_data = d;
        model[a] = d;
        tick();
        init_we = 1'b0;
    endtask

    task request(input logic [14:0] a);
        fill_addr = a;
        fill_req = 1'b1;
        for (int i = 0; i < 4; i++) sb.push_back({2'(i), model[{a[14:2], 2'(i)}]});
    endtask

    task check_int(input string name, input int got, input int want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task test_reset();
        #3;
        compared++;
        if ({busy, rd_valid, fill_done, rd_data, rd_word_idx} !== 13'h0) begin
            mismatched++;
            $display("FAIL reset_outputs: got busy=%b valid=%b done=%b data=%h idx=%0d, want all 0",
                     busy, rd_valid, fill_done, rd_data, rd_word_idx);
        end
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        check_int("reset_idle_busy", int'(busy), 0);
    endtask

    task test_basic();
        preload(15'h1234, 8'hA0);
        preload(15'h1235, 8'hA1);
        preload(15'h1236, 8'hA2);
        preload(15'h1237, 8'hA3);
        restart();
        request(15'h1236);
        for (int j = 1; j <= 9; j++) begin
            tick();
            if (j == 1) fill_req = 1'b0;
            check_int($sformatf("basic_valid_k%0d", k), int'(rd_valid), int'(k >= 4 && k <= 7));
            check_int($sformatf("basic_done_k%0d", k), int'(fill_done), int'(k == 8));
            check_int($sformatf("basic_busy_k%0d", k), int'(busy), int'(k <= 8));
        end
        check_int("basic_words", valid_seen, 4);
        check_int("basic_sb_left", sb.size(), 0);
    endtask

    task test_reset_mid_wait();
        restart();
        request(15'h1234);
        tick();
        fill_req = 1'b0;
        tick();
        #2 reset_n = 1'b0;
        #1;
        compared++;
        if ({busy, rd_valid, fill_done, rd_data} !== 11'h0) begin
            mismatched++;
            $display("FAIL reset_mid_wait: got busy=%b valid=%b done=%b data=%h, want all 0",
                     busy, rd_valid, fill_done, rd_data);
        end
        tick();
        reset_n = 1'b1;
        sb.delete();
        restart();
        repeat (8) tick();
        check_int("after_reset_busy", int'(busy), 0);
        check_int("after_reset_words", valid_seen, 0);
        check_int("after_reset_done", done_seen, 0);
    endtask

    task test_busy_filter();
        preload(15'h0100, 8'h11);
        preload(15'h0101, 8'h12);
        preload(15'h0102, 8'h13);
        preload(15'h0103, 8'h14);
        restart();
        request(15'h1234);
        tick();
        fill_req = 1'b0;
        tick();
        fill_req = 1'b1;
        fill_addr = 15'h0100;
        tick();
        fill_req = 1'b0;
        tick();
        tick();
        fill_req = 1'b1;
        tick();
        fill_req = 1'b0;
        repeat (10) tick();
        check_int("filter_done_count", done_seen, 1);
        check_int("filter_words", valid_seen, 4);
        check_int("filter_sb_left", sb.size(), 0);
        check_int("filter_busy_end", int'(busy), 0);
    endtask

    task test_held_request();
        int fd1, v2, idle_busy, busy10;
        fd1 = 0;
        v2 = 0;
        idle_busy = -1;
        busy10 = -1;
        restart();
        request(15'h1234);
        request(15'h1234);
        for (int j = 1; j <= 22; j++) begin
            tick();
            if (j == 10) fill_req = 1'b0;
            if (j == 9) idle_busy = int'(busy);
            if (j == 10) busy10 = int'(busy);
            if (rd_valid && fd1 != 0 && v2 == 0) v2 = k;
            if (fill_done && fd1 == 0) fd1 = k;
        end
        check_int("held_first_done_k", fd1, 8);
        check_int("held_idle_gap_busy", idle_busy, 0);
        check_int("held_second_busy", busy10, 1);
        check_int("held_second_first_valid_k", v2, 13);
        check_int("held_done_count", done_seen, 2);
        check_int("held_words", valid_seen, 8);
        check_int("held_sb_left", sb.size(), 0);
    endtask

    task test_same_edge();
        preload(15'h0040, 8'h30);
        preload(15'h0041, 8'h31);
        preload(15'h0042, 8'h32);
        preload(15'h0043, 8'h33);
        restart();
        init_we = 1'b1;
        init_addr = 15'h0041;
        init_data = 8'h5A;
        model[15'h0041] = 8'h5A;
        request(15'h0040);
        tick();
        init_we = 1'b0;
        fill_req = 1'b0;
        repeat (3) tick();
        init_we = 1'b1;
        init_addr = 15'h0042;
        init_data = 8'hEE;
        tick();
        init_we = 1'b0;
        repeat (6) tick();
        check_int("same_edge_words", valid_seen, 4);
        check_int("same_edge_done", done_seen, 1);
        restart();
        request(15'h0040);
        tick();
        fill_req = 1'b0;
        repeat (9) tick();
        check_int("dropped_write_words", valid_seen, 4);
        check_int("dropped_write_sb_left", sb.size(), 0);
    endtask

    task test_top_line();
        preload(15'h7FFC, 8'hC0);
        preload(15'h7FFD, 8'hC1);
        preload(15'h7FFE, 8'hC2);
        preload(15'h7FFF, 8'hC3);
        preload(15'h0000, 8'hD0);
        preload(15'h0001, 8'hD1);
        preload(15'h0002, 8'hD2);
        preload(15'h0003, 8'hD3);
        restart();
        request(15'h7FFF);
        tick();
        fill_req = 1'b0;
        repeat (9) tick();
        check_int("top_words", valid_seen, 4);
        check_int("top_done", done_seen, 1);
        check_int("top_sb_left", sb.size(), 0);
        restart();
        request(15'h7FFD);
        tick();
        fill_req = 1'b0;
        repeat (4) tick();
        #2 reset_n = 1'b0;
        #1;
        check_int("burst_reset_valid", int'(rd_valid), 0);
        check_int("burst_reset_busy", int'(busy), 0);
        tick();
        reset_n = 1'b1;
        sb.delete();
        repeat (10) tick();
        check_int("burst_reset_words", valid_seen, 2);
        check_int("burst_reset_done", done_seen, 0);
        restart();
        request(15'h1234);
        tick();
        fill_req = 1'b0;
        repeat (9) tick();
        check_int("post_reset_words", valid_seen, 4);
        check_int("post_reset_done", done_seen, 1);
        check_int("post_reset_sb_left", sb.size(), 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reset_mid_wait();
        test_busy_filter();
        test_held_request();
        test_same_edge();
        test_top_line();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
